// File: rtl/tl_crossbar.sv
// Single-owner TileLink-UL crossbar: round-robin bus ownership, address
// decode onto NS slaves, one outstanding transaction, local decode-error replies.
module tl_crossbar #(
    parameter int NM = 16,
    parameter int NS = 64,
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NM-1:0]   request,
    output logic [NM-1:0]   grant,
    input  logic            m_a_valid   [NM],
    input  logic [2:0]      m_a_opcode  [NM],
    input  logic [2:0]      m_a_size    [NM],
    input  logic [AW-1:0]   m_a_address [NM],
    input  logic [DW/8-1:0] m_a_mask    [NM],
    input  logic [DW-1:0]   m_a_data    [NM],
    output logic            m_a_ready   [NM],
    output logic            m_d_valid   [NM],
    output logic [2:0]      m_d_opcode  [NM],
    output logic [DW-1:0]   m_d_data    [NM],
    output logic            m_d_error   [NM],
    input  logic            m_d_ready   [NM],
    output logic            s_a_valid   [NS],
    output logic [2:0]      s_a_opcode  [NS],
    output logic [2:0]      s_a_size    [NS],
    output logic [AW-1:0]   s_a_address [NS],
    output logic [DW/8-1:0] s_a_mask    [NS],
    output logic [DW-1:0]   s_a_data    [NS],
    input  logic            s_a_ready   [NS],
    input  logic            s_d_valid   [NS],
    input  logic [2:0]      s_d_opcode  [NS],
    input  logic [DW-1:0]   s_d_data    [NS],
    input  logic            s_d_error   [NS],
    output logic            s_d_ready   [NS]
);

    localparam int MW = $clog2(NM);

    typedef enum logic {IDLE, OWNED} state_e;

    state_e        state_q;
    logic [NM-1:0] grant_q;
    logic [MW-1:0] owner_q;
    logic [MW-1:0] last_q;
    logic [5:0]    slv_q;
    logic          out_q;
    logic          err_q;

    logic [MW-1:0] win;
    logic [AW-1:0] a_addr;
    logic [5:0]    sidx;
    logic          owned;
    logic          busy;
    logic          dec_err;
    logic          a_valid;
    logic          a_ready;
    logic          a_fire;
    logic          d_valid;
    logic          d_ready;
    logic          d_fire;

    // rst_n is asserted high; gating here keeps every handshake low during reset
    assign owned   = (state_q == OWNED) && !rst_n;
    assign busy    = out_q || err_q;
    assign a_addr  = m_a_address[owner_q];
    assign sidx    = a_addr[29:24];
    assign dec_err = |a_addr[AW-1:30];
    assign a_valid = owned && !busy && m_a_valid[owner_q];
    assign a_ready = owned && !busy && (dec_err || s_a_ready[sidx]);
    assign a_fire  = a_valid && a_ready;
    assign d_valid = owned && (out_q ? s_d_valid[slv_q] : err_q);
    assign d_ready = m_d_ready[owner_q];
    assign d_fire  = d_valid && d_ready;
    assign grant   = grant_q;

    // Descending scan so the lowest offset above last_q wins; last_q itself is last.
    always_comb begin
        win = last_q;
        for (int k = NM; k >= 1; k--) begin
            if (request[last_q + MW'(k)]) begin
                win = last_q + MW'(k);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NM; i++) begin
            m_a_ready[i]  = 1'b0;
            m_d_valid[i]  = 1'b0;
            m_d_opcode[i] = out_q ? s_d_opcode[slv_q] : 3'd0;
            m_d_data[i]   = out_q ? s_d_data[slv_q] : '0;
            m_d_error[i]  = out_q ? s_d_error[slv_q] : err_q;
        end
        for (int j = 0; j < NS; j++) begin
            s_a_valid[j]   = 1'b0;
            s_a_opcode[j]  = m_a_opcode[owner_q];
            s_a_size[j]    = m_a_size[owner_q];
            s_a_address[j] = a_addr;
            s_a_mask[j]    = m_a_mask[owner_q];
            s_a_data[j]    = m_a_data[owner_q];
            s_d_ready[j]   = 1'b0;
        end
        m_a_ready[owner_q] = a_ready;
        m_d_valid[owner_q] = d_valid;
        s_a_valid[sidx]    = a_valid && !dec_err;
        s_d_ready[slv_q]   = owned && out_q && d_ready;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= MW'(NM - 1);
            slv_q   <= '0;
            out_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|request) begin
                        grant_q <= NM'(1) << win;
                        owner_q <= win;
                        state_q <= OWNED;
                    end
                end
                OWNED: begin
                    if (a_fire) begin
                        out_q <= !dec_err;
                        err_q <= dec_err;
                        slv_q <= sidx;
                    end else if (d_fire) begin
                        out_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                    // Ownership is only surrendered with nothing in flight.
                    if (!request[owner_q] && !a_fire && (!busy || d_fire)) begin
                        grant_q <= '0;
                        last_q  <= owner_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_crossbar.sv
// Directed bench for tl_crossbar: arbitration, routing, decode error,
// slave back-pressure and asynchronous reset abort.
module tb_tl_crossbar;

    localparam int NM = 16;
    localparam int NS = 64;
    localparam int AW = 64;
    localparam int DW = 64;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [NM-1:0]   request;
    logic [NM-1:0]   grant;
    logic            m_a_valid   [NM];
    logic [2:0]      m_a_opcode  [NM];
    logic [2:0]      m_a_size    [NM];
    logic [AW-1:0]   m_a_address [NM];
    logic [DW/8-1:0] m_a_mask    [NM];
    logic [DW-1:0]   m_a_data    [NM];
    logic            m_a_ready   [NM];
    logic            m_d_valid   [NM];
    logic [2:0]      m_d_opcode  [NM];
    logic [DW-1:0]   m_d_data    [NM];
    logic            m_d_error   [NM];
    logic            m_d_ready   [NM];
    logic            s_a_valid   [NS];
    logic [2:0]      s_a_opcode  [NS];
    logic [2:0]      s_a_size    [NS];
    logic [AW-1:0]   s_a_address [NS];
    logic [DW/8-1:0] s_a_mask    [NS];
    logic [DW-1:0]   s_a_data    [NS];
    logic            s_a_ready   [NS];
    logic            s_d_valid   [NS];
    logic [2:0]      s_d_opcode  [NS];
    logic [DW-1:0]   s_d_data    [NS];
    logic            s_d_error   [NS];
    logic            s_d_ready   [NS];

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tl_crossbar #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .request     (request),
        .grant       (grant),
        .m_a_valid   (m_a_valid),
        .m_a_opcode  (m_a_opcode),
        .m_a_size    (m_a_size),
        .m_a_address (m_a_address),
        .m_a_mask    (m_a_mask),
        .m_a_data    (m_a_data),
        .m_a_ready   (m_a_ready),
        .m_d_valid   (m_d_valid),
        .m_d_opcode  (m_d_opcode),
        .m_d_data    (m_d_data),
        .m_d_error   (m_d_error),
        .m_d_ready   (m_d_ready),
        .s_a_valid   (s_a_valid),
        .s_a_opcode  (s_a_opcode),
        .s_a_size    (s_a_size),
        .s_a_address (s_a_address),
        .s_a_mask    (s_a_mask),
        .s_a_data    (s_a_data),
        .s_a_ready   (s_a_ready),
        .s_d_valid   (s_d_valid),
        .s_d_opcode  (s_d_opcode),
        .s_d_data    (s_d_data),
        .s_d_error   (s_d_error),
        .s_d_ready   (s_d_ready)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    function automatic int n_sav();
        int c = 0;
        for (int j = 0; j < NS; j++) begin
            if (s_a_valid[j]) c++;
        end
        return c;
    endfunction

    initial begin
        request = 16'h0003;
        for (int i = 0; i < NM; i++) begin
            m_a_valid[i]   = 1'b0;
            m_a_opcode[i]  = 3'd0;
            m_a_size[i]    = 3'd0;
            m_a_address[i] = '0;
            m_a_mask[i]    = '0;
            m_a_data[i]    = '0;
            m_d_ready[i]   = 1'b0;
        end
        for (int j = 0; j < NS; j++) begin
            s_a_ready[j]  = 1'b0;
            s_d_valid[j]  = 1'b0;
            s_d_opcode[j] = 3'd0;
            s_d_data[j]   = '0;
            s_d_error[j]  = 1'b0;
        end

        // reset held with requests pending
        edge1();
        edge1();
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_aready", 64'(m_a_ready[0]), 64'h0);
        @(negedge clk);
        rst_n = 1'b0;
        edge1();
        check("first_grant", 64'(grant), 64'h1);
        edge1();
        check("no_preempt", 64'(grant), 64'h1);

        // round robin hand-over with one idle cycle
        request = 16'h0002;
        edge1();
        check("rr_gap", 64'(grant), 64'h0);
        edge1();
        check("rr_next", 64'(grant), 64'h2);
        request = 16'h0000;
        edge1();
        check("release", 64'(grant), 64'h0);
        request = 16'h0001;
        edge1();
        check("wrap_grant", 64'(grant), 64'h1);

        // master0 read from ROM
        m_a_valid[0]   = 1'b1;
        m_a_opcode[0]  = 3'd4;
        m_a_size[0]    = 3'd2;
        m_a_address[0] = 64'h0100_0010;
        m_a_mask[0]    = 8'h0F;
        s_a_ready[1]   = 1'b1;
        m_d_ready[0]   = 1'b1;
        #1;
        check("rd_sav1", 64'(s_a_valid[1]), 64'h1);
        check("rd_savcnt", 64'(n_sav()), 64'h1);
        check("rd_addr", s_a_address[1], 64'h0100_0010);
        check("rd_opc", 64'(s_a_opcode[1]), 64'h4);
        check("rd_aready", 64'(m_a_ready[0]), 64'h1);
        check("nonowner_aready", 64'(m_a_ready[1]), 64'h0);
        edge1();
        m_a_valid[0] = 1'b0;
        s_d_valid[1] = 1'b1;
        s_d_data[1]  = 64'hDEAD_BEEF;
        s_d_error[1] = 1'b0;
        #1;
        check("rd_block", 64'(m_a_ready[0]), 64'h0);
        check("rd_dvalid", 64'(m_d_valid[0]), 64'h1);
        check("rd_ddata", m_d_data[0], 64'hDEAD_BEEF);
        check("rd_derr", 64'(m_d_error[0]), 64'h0);
        check("rd_sdready", 64'(s_d_ready[1]), 64'h1);
        check("nonowner_dvalid", 64'(m_d_valid[1]), 64'h0);
        edge1();
        s_d_valid[1] = 1'b0;
        s_d_data[1]  = '0;
        #1;
        check("rd_done", 64'(m_d_valid[0]), 64'h0);
        check("rd_free", 64'(m_a_ready[0]), 64'h1);

        // master1 write to an unmapped address
        request = 16'h0002;
        edge1();
        check("rr2_gap", 64'(grant), 64'h0);
        edge1();
        check("rr2_next", 64'(grant), 64'h2);
        m_a_valid[1]   = 1'b1;
        m_a_opcode[1]  = 3'd0;
        m_a_size[1]    = 3'd3;
        m_a_address[1] = 64'h4000_0000;
        m_a_mask[1]    = 8'hFF;
        m_a_data[1]    = 64'h1234;
        m_d_ready[1]   = 1'b0;
        #1;
        check("de_aready", 64'(m_a_ready[1]), 64'h1);
        check("de_savcnt", 64'(n_sav()), 64'h0);
        edge1();
        m_a_valid[1] = 1'b0;
        #1;
        check("de_dvalid", 64'(m_d_valid[1]), 64'h1);
        check("de_derr", 64'(m_d_error[1]), 64'h1);
        check("de_ddata", m_d_data[1], 64'h0);
        edge1();
        check("de_hold", 64'(m_d_valid[1]), 64'h1);
        m_d_ready[1] = 1'b1;
        edge1();
        check("de_done", 64'(m_d_valid[1]), 64'h0);

        // RAM slave stalls channel A for three cycles
        m_d_ready[1]   = 1'b0;
        m_a_valid[1]   = 1'b1;
        m_a_opcode[1]  = 3'd4;
        m_a_address[1] = 64'h0300_0000;
        s_a_ready[3]   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            check("st_aready", 64'(m_a_ready[1]), 64'h0);
            check("st_sav", 64'(s_a_valid[3]), 64'h1);
            check("st_addr", s_a_address[3], 64'h0300_0000);
            edge1();
        end
        s_a_ready[3] = 1'b1;
        #1;
        check("st_hs", 64'(m_a_ready[1]), 64'h1);
        edge1();
        check("st_one_sav", 64'(s_a_valid[3]), 64'h0);
        check("st_one_ready", 64'(m_a_ready[1]), 64'h0);

        // asynchronous reset with a response pending
        s_d_valid[3] = 1'b1;
        s_d_data[3]  = 64'h55;
        #1;
        check("ar_pre", 64'(m_d_valid[1]), 64'h1);
        rst_n = 1'b1;
        #1;
        check("ar_grant", 64'(grant), 64'h0);
        check("ar_dvalid", 64'(m_d_valid[1]), 64'h0);
        check("ar_sdready", 64'(s_d_ready[3]), 64'h0);
        check("ar_aready", 64'(m_a_ready[1]), 64'h0);
        check("ar_savcnt", 64'(n_sav()), 64'h0);
        request      = 16'h0001;
        m_a_valid[1] = 1'b0;
        s_d_valid[3] = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        edge1();
        check("ar_regrant", 64'(grant), 64'h1);
        check("ar_no_resp", 64'(m_d_valid[0]), 64'h0);
        check("ar_clean", 64'(m_a_ready[0]), 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/tl_crossbar.md
TL_CROSSBAR -- requirements
Module: tl_crossbar

Interface
REQ-001 Parameters: NM = 16 (master ports); NS = 64 (slave ports); AW = 64 (address width); DW = 64 (data width).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst_n  input  1  asynchronous reset, asserted HIGH despite the name.
REQ-005 request  input  16  per-master bus request; bit0 = instruction fetch, bit1 = memory access, bits 2-15 tied low.
REQ-006 grant  output  16  one-hot bus grant to the owning master.
REQ-007 m_a_valid/m_a_opcode[3]/m_a_size[3]/m_a_address[64]/m_a_mask[8]/m_a_data[64]  input  per master  channel A.
REQ-008 m_a_ready  output  per master  channel A accept.
REQ-009 m_d_valid/m_d_opcode[3]/m_d_data[64]/m_d_error  output  per master  channel D.
REQ-010 m_d_ready  input  per master  channel D accept.
REQ-011 s_a_valid/s_a_opcode/s_a_size/s_a_address/s_a_mask/s_a_data  output  per slave  channel A, field widths as REQ-007.
REQ-012 s_a_ready  input  per slave  channel A accept.
REQ-013 s_d_valid/s_d_opcode/s_d_data/s_d_error  input  per slave  channel D, field widths as REQ-009.
REQ-014 s_d_ready  output  per slave  channel D accept.
REQ-015 Per-master/per-slave signals are arrays indexed 0..NM-1 / 0..NS-1.

Function
REQ-016 Arbiter states: IDLE (grant = 0) and OWNED (grant one-hot).
REQ-017 IDLE with request != 0: the next edge selects the winner round-robin, searching upward from last_owner+1 and wrapping 15->0, sets grant and enters OWNED.
REQ-018 OWNED: grant holds while request[owner] = 1; the owner is never pre-empted.
REQ-019 OWNED with request[owner] = 0 at an edge: grant = 0 and state IDLE for at least one cycle; last_owner is updated.
REQ-020 Only the owner's channel A is routed; every non-owner sees m_a_ready = 0 and m_d_valid = 0.
REQ-021 Slave index = m_a_address[29:24] of the owner, decoded combinationally.
REQ-022 Slave map: 0 zero page (address 0x0000_0000), 1 ROM (0x0100_0000), 2 UART (0x0200_0000), 3 RAM (0x0300_0000).
REQ-023 Decoded slave: s_a_valid = m_a_valid of the owner, A fields passed unchanged; all other slaves have s_a_valid = 0.
REQ-024 Decoded slave's s_a_ready is returned on the owner's m_a_ready.
REQ-025 On an A handshake (valid & ready), the slave index is latched; channel D is routed from the latched slave to the owner.
REQ-026 Channel D routing: m_d_* of the owner = s_d_* of the latched slave; s_d_ready of the latched slave = m_d_ready of the owner; all other s_d_ready = 0.
REQ-027 Only one transaction may be outstanding; the owner's m_a_ready is forced 0 until the matching D handshake completes.
REQ-028 Decode error (m_a_address[63:30] != 0): the crossbar accepts the A beat itself (m_a_ready = 1) and asserts no s_a_valid.
REQ-029 Decode-error response: next cycle m_d_valid = 1, m_d_error = 1, m_d_data = 0, held until m_d_ready = 1.
REQ-030 request[owner] dropping with a transaction outstanding: the D response is still delivered; grant clears only after the D handshake.
REQ-031 All routing paths are combinational (zero added latency); only grant, last_owner, the latched slave index, the outstanding flag and the decode-error response are registered.

Reset
REQ-032 While rst_n = 1 (asynchronous): grant = 0, state IDLE, last_owner = 15 (so master 0 wins first), outstanding cleared, error response cleared.
REQ-033 During reset: all m_a_ready, m_d_valid, s_a_valid and s_d_ready = 0.
REQ-034 Reset asserted mid-transaction aborts the transaction immediately with no response delivered.

Verification
REQ-035 Reset held, request = 0x0003 -> grant = 0x0000 throughout; first edge after release -> grant = 0x0001.
REQ-036 request = 0x0003, then request[0] dropped -> grant 0x0001 -> 0x0000 (one cycle) -> 0x0002.
REQ-037 Master0 read at 0x0100_0010 -> only s_a_valid[1] = 1; slave1 returns d_data 0xDEAD_BEEF -> m_d_data[0] = 0xDEAD_BEEF, m_d_error = 0.
REQ-038 Master1 write at 0x4000_0000 -> no s_a_valid asserted; next cycle m_d_valid[1] = 1, m_d_error[1] = 1.
REQ-039 Slave holds s_a_ready = 0 for 3 cycles -> master A fields stable, m_a_ready = 0 for 3 cycles, then a single handshake.
REQ-040 rst_n pulsed high while s_d_valid pending -> all outputs 0 within the same cycle; grant = 0x0001 one edge after release with request[0] = 1.
